goldschmidt_ctrl: RTL and testbench

GOLDSCHMIDT_CTRL -- requirements
Module: goldschmidt_ctrl

---
 rtl/gs_pkg.sv | 89 ++++++++
 rtl/goldschmidt_ctrl.sv | 79 +++++++
 tb/tb_goldschmidt_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// Shared definitions for the Goldschmidt divide/sqrt controller: states,
// datapath mux encodings, counter width and the per-state control decode.
package gs_pkg;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned MA_W  = 3;
  localparam int unsigned MB_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_A,
    S_INIT_B,
    S_IT_A,
    S_IT_B,
    S_IT_C,
    S_FINAL
  } state_e;

  // A-mux selects
  localparam logic [MA_W-1:0] MA_NEXT = 3'b000;
  localparam logic [MA_W-1:0] MA_DEXT = 3'b001;
  localparam logic [MA_W-1:0] MA_RA   = 3'b010;
  localparam logic [MA_W-1:0] MA_RB   = 3'b011;
  localparam logic [MA_W-1:0] MA_RK   = 3'b100;
  localparam logic [MA_W-1:0] MA_IA   = 3'b101;

  // B-mux selects
  localparam logic [MB_W-1:0] MB_IA   = 2'b00;
  localparam logic [MB_W-1:0] MB_NEXT = 2'b01;
  localparam logic [MB_W-1:0] MB_RK   = 2'b10;

  typedef struct packed {
    logic [MA_W-1:0] ma;
    logic [MB_W-1:0] mb;
    logic            ms;
    logic            mq;
    logic            la;
    logic            lb;
    logic            lk;
    logic            busy;
    logic            done;
  } ctrl_t;

  // Control word presented to the datapath while the FSM sits in state s.
  function automatic ctrl_t gs_decode(input state_e s, input logic mode);
    ctrl_t c;
    c      = '0;
    c.ms   = mode;
    c.busy = (s != S_IDLE);
    case (s)
      S_INIT_A: begin
        c.ma = MA_NEXT;
        c.mb = MB_IA;
        c.la = 1'b1;
      end
      S_INIT_B: begin
        c.ma = mode ? MA_RA : MA_DEXT;
        c.mb = MB_IA;
        c.lb = 1'b1;
        c.lk = 1'b1;
      end
      S_IT_A: begin
        c.ma = MA_RA;
        c.mb = MB_RK;
        c.la = 1'b1;
      end
      S_IT_C: begin
        c.ma = MA_RK;
        c.mb = MB_RK;
        c.lk = 1'b1;
        c.mq = 1'b1;
      end
      S_IT_B: begin
        c.ma = MA_RB;
        c.mb = MB_RK;
        c.lb = 1'b1;
        c.lk = 1'b1;
      end
      S_FINAL: begin
        c.ma   = MA_RA;
        c.mb   = MB_RK;
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt divide / square-root sequencer. Every output is a flop loaded
// with the decode of the next state, so outputs never see start/op_sqrt.
module goldschmidt_ctrl
  import gs_pkg::*;
#(
  parameter int unsigned ITER = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op_sqrt,
  output logic [MA_W-1:0] Ma,
  output logic [MB_W-1:0] Mb,
  output logic            Ms,
  output logic            Mq,
  output logic            La,
  output logic            Lb,
  output logic            Lk,
  output logic            busy,
  output logic            done
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl_q, ctrl_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= gs_decode(S_IDLE, 1'b0);
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT_A;
          mode_d  = op_sqrt;
          cnt_d   = '0;
        end
      end
      S_INIT_A: state_d = S_INIT_B;
      S_INIT_B: state_d = S_IT_A;
      // sqrt squares Rk in an extra step before refining Rb
      S_IT_A:   state_d = mode_q ? S_IT_C : S_IT_B;
      S_IT_C:   state_d = S_IT_B;
      S_IT_B: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q < CNT_W'(ITER - 1)) ? S_IT_A : S_FINAL;
      end
      S_FINAL:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ctrl_d = gs_decode(state_d, mode_d);
  end

  assign Ma   = ctrl_q.ma;
  assign Mb   = ctrl_q.mb;
  assign Ms   = ctrl_q.ms;
  assign Mq   = ctrl_q.mq;
  assign La   = ctrl_q.la;
  assign Lb   = ctrl_q.lb;
  assign Lk   = ctrl_q.lk;
  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Bench for goldschmidt_ctrl: per-cycle control words compared against a
// sequence model built from the operation's step list (ITER=3 and ITER=1).
module tb_goldschmidt_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, start1, op_sqrt;

  logic [2:0] Ma, Ma1;
  logic [1:0] Mb, Mb1;
  logic Ms, Mq, La, Lb, Lk, busy, done;
  logic Ms1, Mq1, La1, Lb1, Lk1, busy1, done1;

  int checks = 0;
  int failures = 0;
  logic last_mode = 1'b0;

  always #5 clk = ~clk;

  goldschmidt_ctrl #(.ITER(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sqrt(op_sqrt),
    .Ma(Ma), .Mb(Mb), .Ms(Ms), .Mq(Mq), .La(La), .Lb(Lb), .Lk(Lk),
    .busy(busy), .done(done)
  );

  goldschmidt_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_sqrt(op_sqrt),
    .Ma(Ma1), .Mb(Mb1), .Ms(Ms1), .Mq(Mq1), .La(La1), .Lb(Lb1), .Lk(Lk1),
    .busy(busy1), .done(done1)
  );

  wire [11:0] obs3 = {Ma, Mb, Ms, Mq, La, Lb, Lk, busy, done};
  wire [11:0] obs1 = {Ma1, Mb1, Ms1, Mq1, La1, Lb1, Lk1, busy1, done1};

  function automatic logic [11:0] v(input logic [2:0] ma, input logic [1:0] mb,
                                    input logic ms, input logic mq, input logic la,
                                    input logic lb, input logic lk, input logic bsy,
                                    input logic dn);
    return {ma, mb, ms, mq, la, lb, lk, bsy, dn};
  endfunction

  function automatic logic [11:0] idle_word(input logic m);
    return v(3'b000, 2'b00, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Expected cycle-by-cycle words of one operation, from the step tables.
  function automatic void build(input logic m, input int iters, output logic [11:0] q[$]);
    q = {};
    q.push_back(v(3'b000, 2'b00, m, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(v(m ? 3'b010 : 3'b001, 2'b00, m, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int k = 0; k < iters; k++) begin
      q.push_back(v(3'b010, 2'b10, m, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      if (m) q.push_back(v(3'b100, 2'b10, m, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      q.push_back(v(3'b011, 2'b10, m, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    end
    q.push_back(v(3'b010, 2'b10, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
  endfunction

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation; noise toggles op_sqrt and jitters start while busy.
  task automatic run_op(input logic m, input bit on1, input bit noise, input bit hold);
    logic [11:0] q[$];
    int iters, done_at, lat;
    iters = on1 ? 1 : 3;
    build(m, iters, q);
    if (on1) start1 = 1'b1; else start = 1'b1;
    op_sqrt = m;
    tick();
    done_at = 0;
    for (int i = 1; i <= q.size(); i++) begin
      check(on1 ? "op_cycle_it1" : "op_cycle", on1 ? obs1 : obs3, q[i-1]);
      check("la_lb_excl", 12'(on1 ? (La1 & Lb1) : (La & Lb)), 12'd0);
      if ((on1 ? done1 : done) === 1'b1 && done_at == 0) done_at = i;
      if (on1) start1 = hold ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
      else     start  = hold ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
      op_sqrt = noise ? ~op_sqrt : m;
      tick();
    end
    lat = 3 + (m ? 3 : 2) * iters;
    check("latency", 12'(done_at), 12'(lat));
    if (!on1) last_mode = m;
    check("post_idle", on1 ? obs1 : obs3, idle_word(on1 ? 1'b0 : m));
  endtask

  initial begin
    logic [11:0] q[$];
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; op_sqrt = 1'b0;
    tick(); tick();
    check("reset_state", obs3, idle_word(1'b0));
    check("reset_state_it1", obs1, idle_word(1'b0));

    // reset wins over start
    start = 1'b1; op_sqrt = 1'b1;
    tick();
    check("rst_over_start", obs3, idle_word(1'b0));
    start = 1'b0; rst_n = 1'b1;
    tick();
    check("idle_hold", obs3, idle_word(1'b0));

    run_op(1'b0, 1'b0, 1'b0, 1'b0);   // divide
    run_op(1'b1, 1'b0, 1'b0, 1'b0);   // sqrt
    run_op(1'b0, 1'b0, 1'b1, 1'b0);   // divide with op_sqrt toggling

    // start held high: one IDLE cycle between operations, none extra
    run_op(1'b0, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check("no_extra_op", obs3, idle_word(1'b1));

    // reset during IT_C of a sqrt aborts without done
    build(1'b1, 3, q);
    start = 1'b1; op_sqrt = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pre_abort", obs3, q[i]);
      if (i < 3) tick();
    end
    rst_n = 1'b0;
    tick();
    check("abort_idle", obs3, idle_word(1'b0));
    rst_n = 1'b1;
    tick();
    check("abort_no_done", obs3, idle_word(1'b0));
    run_op(1'b1, 1'b0, 1'b0, 1'b0);

    // ITER=1 divide
    run_op(1'b0, 1'b1, 1'b0, 1'b0);

    // randomized operations with random idle gaps
    for (int n = 0; n < 16; n++) begin
      int gap;
      run_op(1'($urandom % 2), 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_idle", obs3, idle_word(last_mode));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
